// File: rtl/sram_pkg.sv
// Shared constants and types for the simple-dual-port RAM and its clear sequencer.
package sram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int lane_count(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/sram_if.sv
// Write/read port bundle of sram_dp: the master issues accesses, the RAM (slave) returns data.
interface sram_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
);

  logic [AWIDTH-1:0]   waddr;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wbe;
  logic                we;
  logic [AWIDTH-1:0]   raddr;
  logic                re;
  logic [DWIDTH-1:0]   rdata;
  logic                rvalid;
  logic                busy;

  modport master (
    output waddr, wdata, wbe, we, raddr, re,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  waddr, wdata, wbe, we, raddr, re,
    output rdata, rvalid, busy
  );

endinterface

// File: rtl/sram_clear_seq.sv
// Post-reset zero-clear sequencer: walks every address once, raising busy while it runs.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int AWIDTH         = 12,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [AWIDTH-1:0] clr_addr,
  output logic              clr_we,
  output logic              busy
);

  clr_state_e        state_reg, state_next;
  logic [AWIDTH-1:0] cnt_reg, cnt_next;
  logic              last;

  assign last     = &cnt_reg;
  assign clr_addr = cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // IDLE has no exit, so the counter wrapping after the last word cannot restart a clear.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clr_we   = 1'b1;
        busy     = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (last) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/sram_dp.sv
// Parametrised simple-dual-port RAM: byte-enabled write port, pipelined read port,
// selectable read-during-write behaviour and a post-reset zero clear.
module sram_dp
  import sram_pkg::*;
#(
  parameter int AWIDTH         = 12,
  parameter int DWIDTH         = 16,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic   clk,
  input logic   reset,
  sram_if.slave bus
);

  localparam int NLANES = lane_count(DWIDTH);
  localparam int DEPTH  = 2 ** AWIDTH;
  localparam bit BYPASS = (RDW_MODE == RDW_NEW);

  if (DWIDTH % 8 != 0) begin : g_bad_dwidth
    $error("sram_dp: DWIDTH must be a multiple of 8");
  end

  logic [AWIDTH-1:0] clr_addr;
  logic              clr_we;
  logic              busy;

  sram_clear_seq #(
    .AWIDTH        (AWIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear (
    .clk     (clk),
    .reset   (reset),
    .clr_addr(clr_addr),
    .clr_we  (clr_we),
    .busy    (busy)
  );

  assign bus.busy = busy;

  // Write port mux: the clear sequencer owns the array while busy.
  logic [AWIDTH-1:0] wa;
  logic [DWIDTH-1:0] wd;
  logic [NLANES-1:0] wl;

  always_comb begin
    wa = bus.waddr;
    wd = bus.wdata;
    wl = bus.we ? bus.wbe : '0;
    if (busy) begin
      wa = clr_addr;
      wd = '0;
      wl = {NLANES{clr_we}};
    end
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (wl[i]) begin
        mem[wa][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  logic rd_fire;
  assign rd_fire = bus.re && !busy;

  logic [NLANES-1:0] byp_mask;
  logic [NLANES-1:0] byp_mask_reg;
  logic [DWIDTH-1:0] byp_data_reg;
  logic [DWIDTH-1:0] ram_q_reg;
  logic [DWIDTH-1:0] rd_merged;
  logic              v1_reg;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign byp_mask[gi] = BYPASS && bus.we && (bus.waddr == bus.raddr) && bus.wbe[gi];
    assign rd_merged[8*gi +: 8] = byp_mask_reg[gi] ? byp_data_reg[8*gi +: 8]
                                                   : ram_q_reg[8*gi +: 8];
  end

  // Plain registered read keeps the array mappable to block RAM.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      ram_q_reg <= mem[bus.raddr];
    end
  end

  // Reset forces a full bypass of zero data, so rdata reads 0 without resetting the RAM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg       <= 1'b0;
      byp_mask_reg <= '1;
      byp_data_reg <= '0;
    end else begin
      v1_reg <= rd_fire;
      if (rd_fire) begin
        byp_mask_reg <= byp_mask;
        byp_data_reg <= bus.wdata;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DWIDTH-1:0] rdata_reg;
    logic              rvalid_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_reg  <= '0;
        rvalid_reg <= 1'b0;
      end else begin
        rvalid_reg <= v1_reg;
        if (v1_reg) begin
          rdata_reg <= rd_merged;
        end
      end
    end

    assign bus.rdata  = rdata_reg;
    assign bus.rvalid = rvalid_reg;
  end else begin : g_out_direct
    assign bus.rdata  = rd_merged;
    assign bus.rvalid = v1_reg;
  end

endmodule

// File: doc/sram_dp.md
Name: sram_dp

Overview:
Parametrised simple-dual-port synchronous RAM: one write port with per-byte enables and one read port. Adds over the previous fixed 4Kx16 RAM:
- selectable read-during-write behaviour
- optional output pipeline register
- read-valid strobe
- post-reset zero-clear sequencer with a busy flag

Sits between the CPU/bus masters and on-chip block RAM; drop-in for program/data memory.

Parameters:
AWIDTH, 12, address width; depth = 2**AWIDTH words
DWIDTH, 16, data width; must be a multiple of 8 (elaboration-time assertion)
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged bypass)
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = no clear, busy never asserts

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
waddr  in  AWIDTH  write address
wdata  in  DWIDTH  write data
wbe  in  DWIDTH/8  write byte enables; bit i gates wdata[8i+7:8i]
we  in  1  write strobe
raddr  in  AWIDTH  read address
re  in  1  read strobe
rdata  out  DWIDTH  read data, holds last value between reads
rvalid  out  1  one-cycle pulse; rdata valid this cycle
busy  out  1  clear sequence in progress; writes and reads ignored

Behaviour:
- Reset (synchronous, active-high):
  - rdata=0, rvalid=0, pipeline stage cleared.
  - With CLEAR_ON_RESET=1: state<=CLEAR, clear counter<=0, busy=1 from the cycle after reset is sampled.
  - With CLEAR_ON_RESET=0: state<=IDLE, busy=0.
- Clear FSM, states IDLE and CLEAR:
  - In CLEAR, each cycle writes 0 to mem[cnt] and increments cnt.
  - At cnt=2**AWIDTH-1 the final write occurs, then state<=IDLE and busy<=0 on the next edge.
  - Busy therefore lasts exactly 2**AWIDTH cycles.
  - Reset asserted mid-clear restarts at cnt=0.
  - Counter is AWIDTH+1 bits wide or uses an explicit last-flag; no wrap to 0 may re-enter CLEAR.
- While busy=1: we and re are ignored, rvalid stays 0, rdata is unchanged.
- Write, when we=1 and busy=0: for each i with wbe[i]=1, mem[waddr] byte i <= wdata byte i. Other bytes are untouched. wbe=0 is a no-op.
- Read, when re=1 and busy=0 at edge N:
  - OUT_REG=0: rdata and rvalid=1 appear after edge N (cycle N+1).
  - OUT_REG=1: they appear one cycle later (cycle N+2).
  - Back-to-back reads give one result per cycle, fully pipelined.
  - rvalid is 0 in any cycle without a corresponding read.
- Read-during-write, same cycle with waddr==raddr:
  - RDW_MODE=0: rdata returns the pre-write contents.
  - RDW_MODE=1: enabled bytes come from wdata, disabled bytes from memory.
  - Different addresses: independent, no interaction.
- Reset with a read in flight: the pending rvalid is dropped and no late pulse occurs.
- No memory initialisation other than the clear. With CLEAR_ON_RESET=0, contents before the first write are undefined (X in simulation).

Decomposition:
- Package sram_pkg:
  - RDW_OLD=0, RDW_NEW=1 constants
  - clear-FSM state enum typedef (ST_IDLE, ST_CLEAR)
  - function computing byte-lane count from DWIDTH
- One sub-module, sram_clear_seq: the clear FSM and counter. Outputs clear address, clear write strobe and busy.
- sram_dp muxes the clear strobe onto the write port ahead of the memory array.
- Keep the array inference pattern (registered read, per-byte write loop) so synthesis maps it to block RAM.

Test Plan:
1. Clear: defaults, pulse reset 1 cycle -> busy=1 for exactly 4096 cycles. After busy falls, reading addresses 0, 1, 0xFFF returns 0x0000 with rvalid one cycle after each re.
2. Byte enables: write 0xABCD to 0x010 with wbe=11, then 0x12xx with wbe=10 -> read of 0x010 returns 0x12CD. A write with wbe=00 leaves 0x12CD unchanged.
3. Read-during-write: mem[0x020]=0x1111; same cycle we=1, wdata=0x2222, wbe=01, re=1, both addresses 0x020:
   - RDW_MODE=0 -> read returns 0x1111.
   - RDW_MODE=1 -> read returns 0x1122.
   - Subsequent read returns 0x1122 in both modes.
4. Pipelining with OUT_REG=1: reads of 0x000..0x003 on consecutive cycles (preloaded 0xA0..0xA3) -> rvalid high for 4 consecutive cycles starting 2 cycles after the first re, data in order.
5. Reset mid-clear: assert reset at clear cycle 100 -> busy stays high and lasts 4096 more cycles. A write/read attempted during busy -> no memory change, rvalid=0.
6. Reset with read in flight (OUT_REG=1): re at N, reset at N+1 -> rdata=0 and no rvalid pulse at N+2. With CLEAR_ON_RESET=0 -> busy=0 immediately after reset and the first read returns the previously written data.
